// File: rtl/bo_datapath.sv
// Datapath for the polynomial-evaluation unit: X/H/S registers, operand muxes, shared add/mul ALU.
// Optional BO_OVF_DETECT_EN builds a sticky overflow flag for ALU results loaded into H or S.
module bo_datapath #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   m0,
  input  logic [1:0]   m1,
  input  logic [1:0]   m2,
  input  logic         lx,
  input  logic         ls,
  input  logic         lh,
  input  logic         h,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_a,
  input  logic [W-1:0] coef_b,
  input  logic [W-1:0] coef_c,
  output logic [W-1:0] x_q,
  output logic [W-1:0] h_q,
  output logic [W-1:0] s_q,
  output logic [W-1:0] y_out,
  output logic         y_valid,
  output logic         ovf
);

  logic [W-1:0] op_a, op_b, alu, s_in;
  logic [W-1:0] x_d, h_d, s_d, y_out_d, y_out_q;
  logic         y_valid_d, y_valid_q, dirty_d, dirty_q;

  always_comb begin
    op_a = '0;
    case (m0)
      2'b00: op_a = '0;
      2'b01: op_a = x_q;
      2'b10: op_a = h_q;
      2'b11: op_a = s_q;
    endcase
  end

  always_comb begin
    op_b = s_q;
    case (m1)
      2'b00: op_b = s_q;
      2'b01: op_b = x_q;
      2'b10: op_b = coef_a;
      2'b11: op_b = coef_b;
    endcase
  end

`ifdef BO_OVF_DETECT_EN
  logic [2*W-1:0] prod;
  logic [W:0]     sum;
  logic           alu_wide, ovf_set, ovf_d, ovf_q;

  always_comb begin
    prod     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    sum      = {1'b0, op_a} + {1'b0, op_b};
    alu      = h ? prod[W-1:0] : sum[W-1:0];
    alu_wide = h ? (|prod[2*W-1:W]) : sum[W];
    ovf_set  = alu_wide & (lh | (ls & (m2 == 2'b00)));
    // set wins over the lx clear
    ovf_d    = ovf_set | (ovf_q & ~lx);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic [W-1:0] prod, sum;

  always_comb begin
    prod = op_a * op_b;
    sum  = op_a + op_b;
    alu  = h ? prod : sum;
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    s_in = alu;
    case (m2)
      2'b00: s_in = alu;
      2'b01: s_in = coef_c;
      2'b10: s_in = h_q;
      2'b11: s_in = x_q;
    endcase
  end

  always_comb begin
    x_d       = lx ? x_in : x_q;
    h_d       = lh ? alu  : h_q;
    s_d       = ls ? s_in : s_q;
    dirty_d   = ls | (dirty_q & ~lx);
    y_valid_d = lx & dirty_q;
    y_out_d   = y_valid_d ? s_q : y_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      h_q       <= '0;
      s_q       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      h_q       <= h_d;
      s_q       <= s_d;
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
      dirty_q   <= dirty_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench for bo_datapath: directed plan steps plus random traffic,
// expectations from an integer-arithmetic model pushed to a scoreboard queue.
module tb_bo_datapath;
  localparam int unsigned W = 8;
`ifdef BO_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   m0 = '0, m1 = '0, m2 = '0;
  logic         lx = 1'b0, ls = 1'b0, lh = 1'b0, h = 1'b0;
  logic [W-1:0] x_in = '0, coef_a = '0, coef_b = '0, coef_c = '0;
  logic [W-1:0] x_q, h_q, s_q, y_out;
  logic         y_valid, ovf;

  bo_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .m2(m2),
    .lx(lx), .ls(ls), .lh(lh), .h(h),
    .x_in(x_in), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .x_q(x_q), .h_q(h_q), .s_q(s_q), .y_out(y_out),
    .y_valid(y_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned x, hh, s, y;
    bit          yv, ov;
  } exp_t;

  exp_t        sb[$];
  int unsigned mx, mh, ms, my;
  bit          myv, movf, mdirty;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int unsigned a, b, full, mask, aluv, sin;
    bit          wide;
    mask = (1 << W) - 1;
    a = 0;
    case (m0)
      2'd0: a = 0;
      2'd1: a = mx;
      2'd2: a = mh;
      2'd3: a = ms;
    endcase
    b = 0;
    case (m1)
      2'd0: b = ms;
      2'd1: b = mx;
      2'd2: b = coef_a;
      2'd3: b = coef_b;
    endcase
    full = h ? a * b : a + b;
    aluv = full & mask;
    wide = full > mask;
    sin = 0;
    case (m2)
      2'd0: sin = aluv;
      2'd1: sin = coef_c;
      2'd2: sin = mh;
      2'd3: sin = mx;
    endcase
    if (rst) begin
      mx = 0; mh = 0; ms = 0; my = 0; myv = 0; movf = 0; mdirty = 0;
    end else begin
      myv  = lx && mdirty;
      if (myv) my = ms;
      movf   = (OVF_EN && wide && (lh || (ls && m2 == 2'd0))) || (movf && !lx);
      mdirty = ls || (mdirty && !lx);
      if (lx) mx = x_in;
      if (lh) mh = aluv;
      if (ls) ms = sin;
    end
  endtask

  task automatic drive(input bit r, input logic [1:0] a0, input logic [1:0] a1,
                       input logic [1:0] a2, input bit ilx, input bit ils, input bit ilh,
                       input bit ih, input int unsigned xi, input int unsigned ca,
                       input int unsigned cb, input int unsigned cc);
    exp_t e;
    @(negedge clk);
    rst = r; m0 = a0; m1 = a1; m2 = a2; lx = ilx; ls = ils; lh = ilh; h = ih;
    x_in = xi[W-1:0]; coef_a = ca[W-1:0]; coef_b = cb[W-1:0]; coef_c = cc[W-1:0];
    model_step();
    e.x = mx; e.hh = mh; e.s = ms; e.y = my; e.yv = myv; e.ov = movf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("x_q", 32'(x_q), e.x);
    check("h_q", 32'(h_q), e.hh);
    check("s_q", 32'(s_q), e.s);
    check("y_out", 32'(y_out), e.y);
    check("y_valid", 32'(y_valid), 32'(e.yv));
    check("ovf", 32'(ovf), 32'(e.ov));
  endtask

  task automatic idle();
    drive(0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    mx = 0; mh = 0; ms = 0; my = 0; myv = 0; movf = 0; mdirty = 0;
    // 1: reset with random controls
    for (int unsigned i = 0; i < 2; i++)
      drive(1, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    check("rst_x", 32'(x_q), 0);
    check("rst_s", 32'(s_q), 0);
    check("rst_yv", 32'(y_valid), 0);

    // 2: X=5, H=X*X
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 5, 0, 0, 0);
    check("p2_x", 32'(x_q), 5);
    drive(0, 2'd1, 2'd1, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("p2_h", 32'(h_q), 25);

    // 3: S=H+a, then lx produces the strobe
    drive(0, 2'd2, 2'd2, 2'd0, 0, 1, 0, 0, 0, 3, 0, 0);
    check("p3_s", 32'(s_q), 28);
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 7, 3, 0, 0);
    check("p3_yv", 32'(y_valid), 1);
    check("p3_y", 32'(y_out), 28);
    check("p3_x", 32'(x_q), 7);
    idle();
    check("p3_yv_drop", 32'(y_valid), 0);

    // 4: repeated lx without ls, then S=coef_c
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 7, 0, 0, 0);
    check("p4_yv", 32'(y_valid), 0);
    check("p4_y", 32'(y_out), 28);
    drive(0, 2'd0, 2'd0, 2'd1, 0, 1, 0, 0, 0, 0, 0, 9);
    check("p4_s", 32'(s_q), 9);

    // 5: X=20, H=X*X overflows to 144
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 20, 0, 0, 0);
    drive(0, 2'd1, 2'd1, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("p5_h", 32'(h_q), 144);
    check("p5_ovf", 32'(ovf), 32'(OVF_EN));
    idle();
    check("p5_ovf_hold", 32'(ovf), 32'(OVF_EN));
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 7, 0, 0, 0);
    check("p5_ovf_clr", 32'(ovf), 0);

    // 6: S=X then reset with lx pending: no strobe
    drive(0, 2'd0, 2'd0, 2'd3, 0, 1, 0, 0, 0, 0, 0, 0);
    check("p6_s", 32'(s_q), 7);
    drive(1, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 33, 0, 0, 0);
    check("p6_yv", 32'(y_valid), 0);
    check("p6_s0", 32'(s_q), 0);
    drive(0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, 11, 0, 0, 0);
    check("p6_yv_after", 32'(y_valid), 0);

    // random traffic with occasional reset
    for (int unsigned i = 0; i < 400; i++)
      drive(($urandom_range(0, 19) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
            1'($urandom), $urandom, $urandom, $urandom, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operative block (datapath) on the receiving end of the control word: m0, m1, m2, lx, ls, lh, h.
- Holds three registers: X (input operand), H (temporary) and S (accumulator), plus operand muxes and a shared add/multiply ALU.
- Reports a registered result with a one-cycle valid strobe each time the control returns to the load-X word after an accumulation sequence.
- Sits beside the control FSM in the polynomial-evaluation unit.

Parameters:
W, 8, data width of x_in, coefficients, X, H, S and y_out.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
m0  input  2  operand-A select
m1  input  2  operand-B select
m2  input  2  S-input select
lx  input  1  load X from x_in
ls  input  1  load S
lh  input  1  load H from ALU output
h  input  1  ALU op: 1 = multiply, 0 = add
x_in  input  W  external operand
coef_a  input  W  coefficient a
coef_b  input  W  coefficient b
coef_c  input  W  coefficient c
x_q  output  W  X register
h_q  output  W  H register
s_q  output  W  S register
y_out  output  W  captured result
y_valid  output  1  one-cycle strobe, y_out updated
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high reset rst; clock clk.
  - While rst=1, at each edge X, H, S, y_out are cleared to 0, and y_valid, ovf and the internal dirty flag are cleared to 0.
  - All control inputs are ignored during reset.
- Operand A (m0): 00 = 0, 01 = X, 10 = H, 11 = S.
- Operand B (m1): 00 = S, 01 = X, 10 = coef_a, 11 = coef_b.
- ALU (combinational):
  - h=1: alu = (A*B) mod 2^W, full product kept internally at 2W bits.
  - h=0: alu = (A+B) mod 2^W, internal W+1 bits.
- S input (m2): 00 = alu, 01 = coef_c, 10 = H, 11 = X.
- Register updates, one cycle latency, all from pre-edge values:
  - lx=1: X <= x_in.
  - lh=1: H <= alu.
  - ls=1: S <= m2-selected value.
  - Simultaneous loads are legal. Every source uses old register values, e.g. lx=1 with lh=1 writes H from the old X.
- Dirty flag: dirty <= ls | (dirty & ~lx).
- Result capture:
  - At an edge with lx=1 and dirty=1 (old value): y_out <= S (old value) and y_valid <= 1.
  - Otherwise y_valid <= 0, and y_out holds its value.
  - y_valid never stays high two consecutive cycles unless ls=1 and lx=1 are asserted together on consecutive cycles.
- lx=1 with dirty=0 (e.g. the idle word repeated): no strobe.
- Unused select codes do not exist; every 2-bit code is defined.
- Reset mid-sequence: all state clears on the next edge. No y_valid is produced for the interrupted sequence.

Optional Feature:
- Macro: BO_OVF_DETECT_EN.
- Defined:
  - ovf is set (sticky) at any edge where a load of H (lh=1) or of S (ls=1, m2=00) takes an ALU result whose true value ≥ 2^W.
  - ovf is cleared at an edge with lx=1, unless the same edge also sets it; set wins.
  - ovf is cleared by rst.
- Not defined: ovf is constant 0 and no wide-result compare logic is built. All other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles with random control and data -> x_q=h_q=s_q=y_out=0, y_valid=0, ovf=0.
2. lx=1, x_in=5 -> x_q=5 next cycle. Then m0=01, m1=01, h=1, lh=1 -> h_q=25.
3. With H=25 and coef_a=3: m0=10, m1=10, h=0, ls=1, m2=00 -> s_q=28. Next lx=1, x_in=7 -> y_valid=1 for exactly one cycle, y_out=28, x_q=7.
4. Repeat lx=1 with no intervening ls -> y_valid stays 0, y_out stays 28. Then ls=1, m2=01, coef_c=9 -> s_q=9.
5. X=20: m0=01, m1=01, h=1, lh=1 -> h_q=144. With BO_OVF_DETECT_EN: ovf=1 until the next lx edge. Without it: ovf=0 throughout.
6. ls=1 (m2=11, S=X=7) then rst=1 in the next cycle with lx=1 -> no y_valid, all registers 0. After release, lx=1 -> y_valid stays 0.
